// File: rtl/noc_pkg.sv
// Shared flit types for the tree NoC merge/decode blocks.
// A flit is an address nibble on top of a 5-bit payload.
package noc_pkg;
  localparam int FLIT_W   = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 5;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    SRC0 = 1'b0,
    SRC1 = 1'b1
  } src_t;

  function automatic logic [ADDR_MSB-ADDR_LSB:0] flit_addr(input flit_t f);
    return f[ADDR_MSB:ADDR_LSB];
  endfunction
endpackage

// File: rtl/merge2_arb_if.sv
// Two valid/ready flit inputs plus one merged output link with its source tag.
// slave is the merge block's view, master is the environment's view.
import noc_pkg::*;

interface merge2_arb_if;
  flit_t in0_data;
  logic  in0_valid;
  logic  in0_ready;
  flit_t in1_data;
  logic  in1_valid;
  logic  in1_ready;
  flit_t out_data;
  logic  out_valid;
  logic  out_ready;
  src_t  out_sel;

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready,
    output in0_ready, in1_ready, out_data, out_valid, out_sel
  );

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready,
    input  in0_ready, in1_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, registered priority pointer.
// Zero latency; en low suppresses both grants and freezes the pointer.
module rr_arb2 #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt0,
  output logic gnt1
);
  logic pri_q, pri_d;

  // Pointer flips after every grant, contested or not, so the other side goes next.
  always_comb begin
    gnt0  = en && req0 && (!req1 || !pri_q);
    gnt1  = en && req1 && (!req0 ||  pri_q);
    pri_d = pri_q;
    if (gnt0)      pri_d = 1'b1;
    else if (gnt1) pri_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pri_q <= RR_INIT;
    else        pri_q <= pri_d;
  end
endmodule

// File: rtl/merge2_arb.sv
// Round-robin 2:1 flit merge, 1-cycle latency; stalls both inputs while the output is blocked.
// MERGE2_SKID_EN swaps the output register for a 2-entry FIFO that breaks the out_ready->in_ready path.
import noc_pkg::*;

module merge2_arb #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  merge2_arb_if.slave  bus
);
  logic  en, gnt0, gnt1;
  flit_t win_data;
  src_t  win_sel;

  rr_arb2 #(.RR_INIT(RR_INIT)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (bus.in0_valid),
    .req1  (bus.in1_valid),
    .en    (en),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign bus.in0_ready = gnt0;
  assign bus.in1_ready = gnt1;
  assign win_data      = gnt1 ? bus.in1_data : bus.in0_data;
  assign win_sel       = gnt1 ? SRC1 : SRC0;

`ifdef MERGE2_SKID_EN
  flit_t      dat_q [2];
  src_t       sel_q [2];
  logic       wr_ptr_q, rd_ptr_q, full_q;
  logic [1:0] cnt_q, cnt_d;
  logic       enq, deq;

  // full_q is registered so out_ready never reaches the input readies in the same cycle.
  assign en    = rst_n && !full_q;
  assign enq   = gnt0 || gnt1;
  assign deq   = (cnt_q != 2'd0) && bus.out_ready;
  assign cnt_d = cnt_q + 2'(enq) - 2'(deq);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        dat_q[i] <= '0;
        sel_q[i] <= SRC0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      full_q   <= 1'b0;
    end else begin
      if (enq) begin
        dat_q[wr_ptr_q] <= win_data;
        sel_q[wr_ptr_q] <= win_sel;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == 2'd2);
    end
  end

  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = dat_q[rd_ptr_q];
  assign bus.out_sel   = sel_q[rd_ptr_q];
`else
  flit_t data_q, data_d;
  src_t  sel_q, sel_d;
  logic  valid_q, valid_d;

  // Slot is reusable when empty or draining this cycle, giving full throughput.
  assign en = rst_n && (!valid_q || bus.out_ready);

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q && !bus.out_ready;
    if (gnt0 || gnt1) begin
      data_d  = win_data;
      sel_d   = win_sel;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= SRC0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
`endif
endmodule
